// File: rtl/frame_param_scheduler.sv
// Per-frame parameter scheduler for the zoom/SDRAM-read path: takes toggle-handshaked updates,
// commits them at VS fall and computes the read start address. Optional macro: FRAME_PARAM_CLAMP_EN.
module frame_param_scheduler #(
    parameter int         HOR_SIZE   = 2560,
    parameter int         HOR_PITCH  = 256,
    parameter logic [7:0] DEF_FACTOR = 8'h80,
    parameter int         DEF_WIDTH  = 800,
    parameter int         X_MAX      = 800,
    parameter int         Y_MAX      = 479
) (
    input  logic        clk_vga,
    input  logic        dly_rstn,
    input  logic        i_vs,
    input  logic        i_hs,
    input  logic        i_rd_rst,
    input  logic        i_upd_req,
    input  logic [7:0]  i_scale_factor,
    input  logic [9:0]  i_scale_width,
    input  logic [9:0]  i_x_offset,
    input  logic [8:0]  i_y_offset,
    input  logic [22:0] i_base_addr,
    output logic        o_upd_ack,
    output logic [7:0]  o_scale_factor,
    output logic [9:0]  o_scale_width,
    output logic [6:0]  o_scale_offset,
    output logic [22:0] o_rd_addr,
    output logic        o_rd_load,
    output logic        o_ver_rst,
    output logic        o_hor_rst,
    output logic        o_pending
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COMMIT = 2'd1;
    localparam logic [1:0] S_CALC1  = 2'd2;
    localparam logic [1:0] S_CALC2  = 2'd3;

    localparam logic [9:0] DEF_W_C = 10'(DEF_WIDTH);
    localparam logic [9:0] X_MAX_C = 10'(X_MAX);
    localparam logic [8:0] Y_MAX_C = 9'(Y_MAX);

    // The y-offset product below is hard-wired as (y<<11)+(y<<9) and the x block as <<8.
    if (HOR_SIZE != 2560 || HOR_PITCH != 256) begin : g_bad_geometry
        $error("frame_param_scheduler: shift-add address form needs HOR_SIZE=2560, HOR_PITCH=256");
    end

    function automatic logic [9:0] clamp_x(input logic [9:0] x);
        return (x > X_MAX_C) ? X_MAX_C : x;
    endfunction

    function automatic logic [8:0] clamp_y(input logic [8:0] y);
        return (y > Y_MAX_C) ? Y_MAX_C : y;
    endfunction

    logic [2:0]  r_vs_d, r_hs_d;
    logic        w_vs_fall, w_vs_rise, w_hs_rise;
    logic [1:0]  r_req_s;
    logic        r_req_prev;
    logic        w_upd_edge;
    logic [7:0]  r_sh_factor;
    logic [9:0]  r_sh_width;
    logic [9:0]  r_sh_x;
    logic [8:0]  r_sh_y;
    logic [22:0] r_sh_base;
    logic [1:0]  r_state;
    logic [9:0]  r_x_act;
    logic [8:0]  r_y_act;
    logic [22:0] r_base_act;
    logic [20:0] r_prod_y;
    logic [11:0] r_prod_x;
    logic [20:0] w_y21;

    assign w_vs_fall      = r_vs_d[2] & ~r_vs_d[1];
    assign w_vs_rise      = ~r_vs_d[2] & r_vs_d[1];
    assign w_hs_rise      = ~r_hs_d[2] & r_hs_d[1];
    assign w_upd_edge     = r_req_s[1] ^ r_req_prev;
    assign w_y21          = {12'd0, r_y_act};
    assign o_scale_offset = {1'b0, r_x_act[5:0]};

    always_ff @(posedge clk_vga or negedge dly_rstn) begin
        if (!dly_rstn) begin
            r_vs_d    <= 3'b111;
            r_hs_d    <= 3'b111;
            o_ver_rst <= 1'b0;
            o_hor_rst <= 1'b0;
            o_rd_load <= 1'b0;
        end else begin
            r_vs_d    <= {r_vs_d[1:0], i_vs};
            r_hs_d    <= {r_hs_d[1:0], i_hs};
            o_ver_rst <= w_vs_rise;
            o_hor_rst <= w_hs_rise;
            o_rd_load <= o_ver_rst | i_rd_rst;
        end
    end

    // Capture beats the COMMIT clear, so a coincident update stays pending for the next frame.
    always_ff @(posedge clk_vga or negedge dly_rstn) begin
        if (!dly_rstn) begin
            r_req_s     <= 2'b00;
            r_req_prev  <= 1'b0;
            o_upd_ack   <= 1'b0;
            o_pending   <= 1'b0;
            r_sh_factor <= DEF_FACTOR;
            r_sh_width  <= DEF_W_C;
            r_sh_x      <= '0;
            r_sh_y      <= '0;
            r_sh_base   <= '0;
        end else begin
            r_req_s    <= {r_req_s[0], i_upd_req};
            r_req_prev <= r_req_s[1];
            if (w_upd_edge) begin
                r_sh_factor <= i_scale_factor;
                r_sh_width  <= i_scale_width;
                r_sh_x      <= i_x_offset;
                r_sh_y      <= i_y_offset;
                r_sh_base   <= i_base_addr;
                o_upd_ack   <= ~o_upd_ack;
                o_pending   <= 1'b1;
            end else if (r_state == S_COMMIT) begin
                o_pending   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_vga or negedge dly_rstn) begin
        if (!dly_rstn) begin
            r_state        <= S_IDLE;
            o_scale_factor <= DEF_FACTOR;
            o_scale_width  <= DEF_W_C;
            r_x_act        <= '0;
            r_y_act        <= '0;
            r_base_act     <= '0;
            r_prod_y       <= '0;
            r_prod_x       <= '0;
            o_rd_addr      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_vs_fall && o_pending)
                        r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    o_scale_factor <= r_sh_factor;
                    o_scale_width  <= r_sh_width;
                    r_base_act     <= r_sh_base;
`ifdef FRAME_PARAM_CLAMP_EN
                    r_x_act        <= clamp_x(r_sh_x);
                    r_y_act        <= clamp_y(r_sh_y);
`else
                    r_x_act        <= r_sh_x;
                    r_y_act        <= r_sh_y;
`endif
                    r_state        <= S_CALC1;
                end
                S_CALC1: begin
                    r_prod_y <= (w_y21 << 11) + (w_y21 << 9);
                    r_prod_x <= {r_x_act[9:6], 8'd0};
                    r_state  <= S_CALC2;
                end
                default: begin
                    o_rd_addr <= r_base_act + {2'b00, r_prod_y} + {11'd0, r_prod_x};
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
